pc_branch_unit: RTL

- Program-counter and branch-resolution stage that sits directly downstream of the 8-bit equality comparator.
- Consumes the comparator's `zero` flag together with decoded branch/jump strobes from the control unit.
- Maintains the 8-bit PC, a one-deep link register for call/return, and a sticky halt state.
- Drives the instruction-memory address every cycle.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/pc_next_mux.sv | 59 +++++
 rtl/pc_branch_unit.sv | 94 +++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared constants and encodings for the PC / branch-resolution stage.
package cpu_pkg;

    localparam int unsigned    DEF_PC_W     = 8;
    localparam int unsigned    DEF_OFF_W    = 8;
    localparam logic [7:0]     DEF_RESET_PC = 8'h00;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    typedef enum logic [2:0] {
        SEL_INC,
        SEL_REL,
        SEL_ABS,
        SEL_LINK,
        SEL_HOLD
    } sel_e;

endpackage

// File: rtl/pc_next_mux.sv
// Priority resolution of the next PC from decoded strobes and the comparator flag.
module pc_next_mux
    import cpu_pkg::*;
#(
    parameter int unsigned PC_W  = DEF_PC_W,
    parameter int unsigned OFF_W = DEF_OFF_W
) (
    input  logic             halt_req,
    input  logic             ret,
    input  logic             call,
    input  logic             jump,
    input  logic             br_eq,
    input  logic             br_ne,
    input  logic             zero,
    input  logic [PC_W-1:0]  pc,
    input  logic [OFF_W-1:0] offset,
    input  logic [PC_W-1:0]  target,
    input  logic [PC_W-1:0]  link,
    output logic [PC_W-1:0]  next_pc,
    output logic             redirect,
    output logic             load_link
);

    sel_e            sel;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] off_ext;

    assign pc_inc  = pc + PC_W'(1);
    assign off_ext = PC_W'($signed(offset));

    always_comb begin
        sel = SEL_INC;
        if (halt_req) begin
            sel = SEL_HOLD;
        end else if (ret) begin
            sel = SEL_LINK;
        end else if (call || jump) begin
            sel = SEL_ABS;
        end else if ((br_eq && zero) || (br_ne && !zero)) begin
            sel = SEL_REL;
        end
    end

    always_comb begin
        next_pc = pc_inc;
        unique case (sel)
            SEL_HOLD: next_pc = pc;
            SEL_LINK: next_pc = link;
            SEL_ABS:  next_pc = target;
            // Relative branches are taken from the fall-through address.
            SEL_REL:  next_pc = pc_inc + off_ext;
            default:  next_pc = pc_inc;
        endcase
    end

    assign redirect  = (sel == SEL_LINK) || (sel == SEL_ABS) || (sel == SEL_REL);
    assign load_link = (sel == SEL_ABS) && call;

endmodule

// File: rtl/pc_branch_unit.sv
// PC register, link register and RUN/HALT state; next-PC choice lives in pc_next_mux.
module pc_branch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned     PC_W     = DEF_PC_W,
    parameter int unsigned     OFF_W    = DEF_OFF_W,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEF_RESET_PC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             zero,
    input  logic             br_eq,
    input  logic             br_ne,
    input  logic             jump,
    input  logic             call,
    input  logic             ret,
    input  logic             halt_req,
    input  logic [OFF_W-1:0] offset,
    input  logic [PC_W-1:0]  target,
    output logic [PC_W-1:0]  pc,
    output logic [PC_W-1:0]  pc_plus1,
    output logic [PC_W-1:0]  link,
    output logic             taken,
    output logic             halted
);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] link_q, link_d;
    logic            taken_q, taken_d;

    logic [PC_W-1:0] next_pc;
    logic            redirect;
    logic            load_link;

    pc_next_mux #(
        .PC_W  (PC_W),
        .OFF_W (OFF_W)
    ) u_pc_next_mux (
        .halt_req  (halt_req),
        .ret       (ret),
        .call      (call),
        .jump      (jump),
        .br_eq     (br_eq),
        .br_ne     (br_ne),
        .zero      (zero),
        .pc        (pc_q),
        .offset    (offset),
        .target    (target),
        .link      (link_q),
        .next_pc   (next_pc),
        .redirect  (redirect),
        .load_link (load_link)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        link_d  = link_q;
        taken_d = 1'b0;
        if (state_q == ST_RUN && en) begin
            pc_d    = next_pc;
            taken_d = redirect;
            if (load_link) begin
                link_d = pc_plus1;
            end
            if (halt_req) begin
                state_d = ST_HALT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            link_q  <= '0;
            taken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            link_q  <= link_d;
            taken_q <= taken_d;
        end
    end

    assign pc       = pc_q;
    assign pc_plus1 = pc_q + PC_W'(1);
    assign link     = link_q;
    assign taken    = taken_q;
    assign halted   = (state_q == ST_HALT);

endmodule
